// File: rtl/wb4_sram.sv
// wb4_sram: WB4 pipelined slave driving an asynchronous SRAM through a 2-entry request queue,
// with configurable wait states, in-order acks, read-to-write turnaround and abort ack suppression.
module wb4_sram #(
   parameter int ARCHBITSZ = 16,
   parameter int SRAMADDRBITSZ = 16,
   parameter int WAITCYCLES = 1
) (
   input  logic                     rst_i,
   input  logic                     clk_i,
   input  logic                     wb4_cyc_i,
   input  logic                     wb4_stb_i,
   input  logic                     wb4_we_i,
   input  logic [ARCHBITSZ-1:0]     wb4_addr_i,
   input  logic [ARCHBITSZ-1:0]     wb4_data_i,
   input  logic [ARCHBITSZ/8-1:0]   wb4_sel_i,
   output logic                     wb4_stall_o,
   output logic                     wb4_ack_o,
   output logic [ARCHBITSZ-1:0]     wb4_data_o,
   output logic                     sram_ce_o,
   output logic                     sram_oe_o,
   output logic                     sram_we_o,
   output logic [SRAMADDRBITSZ-1:0] sram_addr_o,
   output logic [ARCHBITSZ/8-1:0]   sram_be_o,
   output logic [ARCHBITSZ-1:0]     sram_data_o,
   output logic                     sram_data_oe_o,
   input  logic [ARCHBITSZ-1:0]     sram_data_i
);
   localparam int SELW = ARCHBITSZ / 8;
   localparam int OFS = $clog2(SELW);
   localparam int WCW = (WAITCYCLES > 0) ? $clog2(WAITCYCLES + 1) : 1;
   typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
   state_t state, state_n;
   logic q_we [2];
   logic [SRAMADDRBITSZ-1:0] q_addr [2];
   logic [ARCHBITSZ-1:0] q_data [2];
   logic [SELW-1:0] q_sel [2];
   logic wp, rp, push, avail, done, ld, ok, abort, last_rd;
   logic [1:0] cnt;
   logic [WCW-1:0] wcnt;
   // zero-extended so the word slice stays in range for any SRAMADDRBITSZ
   logic [ARCHBITSZ+SRAMADDRBITSZ-1:0] addr_ext;
   assign addr_ext = {{SRAMADDRBITSZ{1'b0}}, wb4_addr_i};
   assign wb4_stall_o = cnt == 2'd2;
   assign push = wb4_cyc_i && wb4_stb_i && !wb4_stall_o;
   always_ff @(posedge clk_i)
      if (push) begin
         q_we[wp] <= wb4_we_i;
         q_addr[wp] <= addr_ext[OFS +: SRAMADDRBITSZ];
         q_data[wp] <= wb4_data_i;
         q_sel[wp] <= wb4_sel_i;
      end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         cnt <= 2'd0;
         wp <= 1'b0;
         rp <= 1'b0;
      end else if (!wb4_cyc_i) begin
         cnt <= 2'd0;
         wp <= 1'b0;
         rp <= 1'b0;
      end else begin
         wp <= wp ^ push;
         rp <= rp ^ ld;
         cnt <= cnt + {1'b0, push} - {1'b0, ld};
      end
   always_comb begin
      done = state == ACCESS && wcnt == '0;
      avail = cnt != 2'd0 && wb4_cyc_i;
      ld = avail && (state == TURN || ((state == IDLE || done) && !(q_we[rp] && last_rd)));
      state_n = ld ? ACCESS :
                (avail && (state == IDLE || done)) ? TURN :
                (state == ACCESS && !done) ? ACCESS : IDLE;
      ok = done && !abort && wb4_cyc_i;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         abort <= 1'b0;
         last_rd <= 1'b0;
         wcnt <= '0;
         wb4_ack_o <= 1'b0;
         wb4_data_o <= '0;
         sram_ce_o <= 1'b0;
         sram_oe_o <= 1'b0;
         sram_we_o <= 1'b0;
         sram_data_oe_o <= 1'b0;
         sram_addr_o <= '0;
         sram_be_o <= '0;
         sram_data_o <= '0;
      end else begin
         abort <= state == ACCESS && !done && (abort || !wb4_cyc_i);
         wb4_ack_o <= ok;
         wb4_data_o <= (ok && sram_oe_o) ? sram_data_i : '0;
         if (ld) begin
            wcnt <= WCW'(WAITCYCLES);
            last_rd <= !q_we[rp];
            sram_ce_o <= 1'b1;
            sram_oe_o <= !q_we[rp];
            sram_we_o <= q_we[rp] && |q_sel[rp];
            sram_data_oe_o <= q_we[rp] && |q_sel[rp];
            sram_addr_o <= q_addr[rp];
            sram_be_o <= q_sel[rp];
            sram_data_o <= q_data[rp];
         end else if (state == ACCESS && !done) begin
            wcnt <= wcnt - 1'b1;
         end else begin
            sram_ce_o <= 1'b0;
            sram_oe_o <= 1'b0;
            sram_we_o <= 1'b0;
            sram_data_oe_o <= 1'b0;
            sram_addr_o <= '0;
            sram_be_o <= '0;
            sram_data_o <= '0;
         end
      end
endmodule

// File: tb/tb_wb4_sram.sv
// tb_wb4_sram: directed cycle-by-cycle checks of wb4_sram (WAITCYCLES=1) against a small SRAM model.
module tb_wb4_sram;
   logic clk_i = 1'b0, rst_i = 1'b0;
   logic wb4_cyc_i = 1'b0, wb4_stb_i = 1'b0, wb4_we_i = 1'b0;
   logic [15:0] wb4_addr_i = '0, wb4_data_i = '0;
   logic [1:0] wb4_sel_i = '0;
   logic wb4_stall_o, wb4_ack_o, sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o;
   logic [15:0] wb4_data_o, sram_addr_o, sram_data_o, sram_data_i;
   logic [1:0] sram_be_o;
   logic [15:0] mem [256] = '{8: 16'hBEEF, 2: 16'hA5C3, 6: 16'hC0DE, default: 16'h0};
   logic [15:0] bmask;
   int total = 0, bad = 0;

   always #5 clk_i = ~clk_i;

   wb4_sram dut (
      .rst_i(rst_i), .clk_i(clk_i),
      .wb4_cyc_i(wb4_cyc_i), .wb4_stb_i(wb4_stb_i), .wb4_we_i(wb4_we_i),
      .wb4_addr_i(wb4_addr_i), .wb4_data_i(wb4_data_i), .wb4_sel_i(wb4_sel_i),
      .wb4_stall_o(wb4_stall_o), .wb4_ack_o(wb4_ack_o), .wb4_data_o(wb4_data_o),
      .sram_ce_o(sram_ce_o), .sram_oe_o(sram_oe_o), .sram_we_o(sram_we_o),
      .sram_addr_o(sram_addr_o), .sram_be_o(sram_be_o), .sram_data_o(sram_data_o),
      .sram_data_oe_o(sram_data_oe_o), .sram_data_i(sram_data_i)
   );

   assign sram_data_i = sram_oe_o ? mem[sram_addr_o[7:0]] : 16'h0;
   assign bmask = {{8{sram_be_o[1]}}, {8{sram_be_o[0]}}};
   always @(posedge clk_i)
      if (sram_we_o) mem[sram_addr_o[7:0]] <= (mem[sram_addr_o[7:0]] & ~bmask) | (sram_data_o & bmask);

   task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d, input logic [1:0] s);
      wb4_stb_i = 1'b1;
      wb4_we_i = w;
      wb4_addr_i = a;
      wb4_data_i = d;
      wb4_sel_i = s;
   endtask

   task automatic test_reset;
      #1 rst_i = 1'b1;
      #1;
      total++;
      if ({wb4_stall_o, wb4_ack_o, sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o, sram_be_o} !== 8'h0 ||
          {wb4_data_o, sram_addr_o, sram_data_o} !== 48'h0) begin
         bad++;
         $display("FAIL reset_outputs got ctl=%b data_o=%h addr=%h sdata=%h exp all zero",
                  {wb4_stall_o, wb4_ack_o, sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o, sram_be_o},
                  wb4_data_o, sram_addr_o, sram_data_o);
      end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i) rst_i = 1'b0;
   endtask

   task automatic test_back_to_back;
      logic [3:0] e;
      int i;
      wb4_cyc_i = 1'b1;
      req(1'b1, 16'h0020, 16'h1111, 2'b11);
      for (int k = 0; k < 9; k++) begin
         @(posedge clk_i); #1;
         if (k < 2) req(1'b1, 16'h0022 + 16'(2 * k), 16'h2222 + 16'(k) * 16'h1111, 2'b11);
         else wb4_stb_i = 1'b0;
         @(negedge clk_i);
         e = {k == 2, k >= 1 && k <= 6, k >= 1 && k <= 6, k == 3 || k == 5 || k == 7};
         total++;
         if ({wb4_stall_o, sram_we_o, sram_data_oe_o, wb4_ack_o} !== e) begin
            bad++;
            $display("FAIL b2b_ctl k=%0d got stall/we/doe/ack=%b exp %b", k,
                     {wb4_stall_o, sram_we_o, sram_data_oe_o, wb4_ack_o}, e);
         end
         total++;
         if (wb4_data_o !== 16'h0) begin
            bad++;
            $display("FAIL b2b_data_o k=%0d got %h exp 0000", k, wb4_data_o);
         end
         if (k >= 1 && k <= 6) begin
            i = (k - 1) / 2;
            total++;
            if ({sram_addr_o, sram_data_o, sram_be_o} !== {16'h0010 + 16'(i), 16'h1111 * 16'(i + 1), 2'b11}) begin
               bad++;
               $display("FAIL b2b_bus k=%0d got addr=%h data=%h be=%b exp addr=%h data=%h be=11", k,
                        sram_addr_o, sram_data_o, sram_be_o, 16'h0010 + 16'(i), 16'h1111 * 16'(i + 1));
            end
         end
      end
      total++;
      if ({mem[16], mem[17], mem[18]} !== {16'h1111, 16'h2222, 16'h3333}) begin
         bad++;
         $display("FAIL b2b_mem got %h %h %h exp 1111 2222 3333", mem[16], mem[17], mem[18]);
      end
   endtask

   task automatic test_read;
      req(1'b0, 16'h0010, 16'h0, 2'b11);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         wb4_stb_i = 1'b0;
         @(negedge clk_i);
         total++;
         if ({sram_ce_o, sram_oe_o, sram_we_o, wb4_ack_o} !== {k == 1 || k == 2, k == 1 || k == 2, 1'b0, k == 3} ||
             wb4_data_o !== ((k == 3) ? 16'hBEEF : 16'h0)) begin
            bad++;
            $display("FAIL read k=%0d got ce/oe/we/ack=%b data_o=%h", k,
                     {sram_ce_o, sram_oe_o, sram_we_o, wb4_ack_o}, wb4_data_o);
         end
         if (k == 1 || k == 2) begin
            total++;
            if (sram_addr_o !== 16'h0008) begin
               bad++;
               $display("FAIL read_addr k=%0d got %h exp 0008", k, sram_addr_o);
            end
         end
      end
   endtask

   task automatic test_rmw;
      logic [4:0] e;
      req(1'b0, 16'h0004, 16'h0, 2'b11);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk_i); #1;
         if (k == 0) req(1'b1, 16'h0004, 16'h1234, 2'b01);
         else wb4_stb_i = 1'b0;
         @(negedge clk_i);
         e = {k == 1 || k == 2 || k == 4 || k == 5, k == 1 || k == 2, k == 4 || k == 5, k == 4 || k == 5, k == 3 || k == 6};
         total++;
         if ({sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o, wb4_ack_o} !== e ||
             wb4_data_o !== ((k == 3) ? 16'hA5C3 : 16'h0)) begin
            bad++;
            $display("FAIL rmw k=%0d got ce/oe/we/doe/ack=%b data_o=%h exp %b", k,
                     {sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o, wb4_ack_o}, wb4_data_o, e);
         end
         if (k == 4 || k == 5) begin
            total++;
            if ({sram_addr_o, sram_be_o} !== {16'h0002, 2'b01}) begin
               bad++;
               $display("FAIL rmw_write k=%0d got addr=%h be=%b exp 0002 01", k, sram_addr_o, sram_be_o);
            end
         end
      end
      total++;
      if (mem[2] !== 16'hA534) begin
         bad++;
         $display("FAIL rmw_mem got %h exp a534", mem[2]);
      end
   endtask

   task automatic test_sel_zero;
      req(1'b1, 16'h0006, 16'hFFFF, 2'b00);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         wb4_stb_i = 1'b0;
         @(negedge clk_i);
         total++;
         if ({sram_ce_o, sram_we_o, sram_data_oe_o, wb4_ack_o} !== {k == 1 || k == 2, 1'b0, 1'b0, k == 3} ||
             wb4_data_o !== 16'h0) begin
            bad++;
            $display("FAIL sel_zero k=%0d got ce/we/doe/ack=%b data_o=%h", k,
                     {sram_ce_o, sram_we_o, sram_data_oe_o, wb4_ack_o}, wb4_data_o);
         end
      end
      total++;
      if (mem[3] !== 16'h0) begin
         bad++;
         $display("FAIL sel_zero_mem got %h exp 0000", mem[3]);
      end
   endtask

   task automatic test_abort;
      logic ce_e;
      req(1'b0, 16'h0008, 16'h0, 2'b11);
      for (int k = 0; k < 9; k++) begin
         @(posedge clk_i); #1;
         if (k == 0) req(1'b0, 16'h000A, 16'h0, 2'b11);
         else if (k == 1) begin
            wb4_cyc_i = 1'b0;
            wb4_stb_i = 1'b0;
         end else if (k == 2) begin
            wb4_cyc_i = 1'b1;
            req(1'b0, 16'h000C, 16'h0, 2'b11);
         end else wb4_stb_i = 1'b0;
         @(negedge clk_i);
         ce_e = k == 1 || k == 2 || k == 4 || k == 5;
         total++;
         if ({sram_ce_o, sram_oe_o, wb4_ack_o} !== {ce_e, ce_e, k == 6} ||
             wb4_data_o !== ((k == 6) ? 16'hC0DE : 16'h0)) begin
            bad++;
            $display("FAIL abort k=%0d got ce/oe/ack=%b data_o=%h", k, {sram_ce_o, sram_oe_o, wb4_ack_o}, wb4_data_o);
         end
         if (ce_e) begin
            total++;
            if (sram_addr_o !== ((k < 3) ? 16'h0004 : 16'h0006)) begin
               bad++;
               $display("FAIL abort_addr k=%0d got %h", k, sram_addr_o);
            end
         end
      end
   endtask

   task automatic test_async_reset;
      req(1'b0, 16'h0010, 16'h0, 2'b11);
      @(posedge clk_i); #1;
      wb4_stb_i = 1'b0;
      @(posedge clk_i); #3;
      total++;
      if (sram_ce_o !== 1'b1) begin
         bad++;
         $display("FAIL areset_pre got ce=%b exp 1", sram_ce_o);
      end
      rst_i = 1'b1;
      #1;
      total++;
      if ({wb4_stall_o, wb4_ack_o, sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o, sram_be_o} !== 8'h0 ||
          {wb4_data_o, sram_addr_o, sram_data_o} !== 48'h0) begin
         bad++;
         $display("FAIL areset_outputs got ctl=%b addr=%h exp all zero",
                  {wb4_stall_o, wb4_ack_o, sram_ce_o, sram_oe_o, sram_we_o, sram_data_oe_o, sram_be_o}, sram_addr_o);
      end
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      total++;
      if ({wb4_stall_o, wb4_ack_o, sram_ce_o} !== 3'b000) begin
         bad++;
         $display("FAIL areset_after got stall/ack/ce=%b exp 000", {wb4_stall_o, wb4_ack_o, sram_ce_o});
      end
      req(1'b0, 16'h0010, 16'h0, 2'b11);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk_i); #1;
         wb4_stb_i = 1'b0;
         @(negedge clk_i);
         total++;
         if ({sram_oe_o, wb4_ack_o} !== {k == 1 || k == 2, k == 3} || wb4_data_o !== ((k == 3) ? 16'hBEEF : 16'h0)) begin
            bad++;
            $display("FAIL areset_read k=%0d got oe/ack=%b data_o=%h", k, {sram_oe_o, wb4_ack_o}, wb4_data_o);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_read();
      test_rmw();
      test_sel_zero();
      test_abort();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
